// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: loads a preset race time, decrements once per divided
// tick while running, supports pause/resume and holds a sticky expired state at 00.
module countdown_timer #(
    parameter int TICK_COUNT = 49_999_999,
    parameter int DIV_WIDTH  = 28
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] hex_out_one,
    output logic [3:0] hex_out_two,
    output logic       tick,
    output logic       expired,
    output logic       running
);

    // state   | meaning
    // IDLE    | preset loaded (or reset), waiting for enable with nonzero digits
    // RUN     | divider counting, digits decrement on each divider wrap
    // PAUSE   | divider and digits frozen until enable returns
    // EXPIRED | reached 00, sticky until load or reset
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [DIV_WIDTH-1:0] DIV_RELOAD = DIV_WIDTH'(TICK_COUNT);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           ones_q, ones_d;
    logic [3:0]           tens_q, tens_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick_q, tick_d;
    logic                 expired_q, expired_d;
    logic                 running_q, running_d;

    logic [3:0] clamp_ones;
    logic [3:0] clamp_tens;
    logic       digits_zero;

    assign clamp_ones  = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
    assign clamp_tens  = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
    assign digits_zero = (ones_q == 4'd0) && (tens_q == 4'd0);

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        div_d   = div_q;
        tick_d  = 1'b0;

        if (load) begin
            ones_d  = clamp_ones;
            tens_d  = clamp_tens;
            div_d   = DIV_RELOAD;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && !digits_zero) begin
                        state_d = S_RUN;
                        div_d   = DIV_RELOAD;
                    end
                end
                S_RUN: begin
                    // The pausing cycle itself consumes no divider count.
                    if (!enable) begin
                        state_d = S_PAUSE;
                    end else if (div_q != '0) begin
                        div_d = div_q - DIV_ONE;
                    end else begin
                        div_d  = DIV_RELOAD;
                        tick_d = 1'b1;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
                            state_d = S_EXPIRED;
                        end
                    end
                end
                S_PAUSE: begin
                    if (enable) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with the digits.
    assign expired_d = (state_d == S_EXPIRED);
    assign running_d = (state_d == S_RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            div_q     <= DIV_RELOAD;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            running_q <= running_d;
        end
    end

    assign hex_out_one = ones_q;
    assign hex_out_two = tens_q;
    assign tick        = tick_q;
    assign expired     = expired_q;
    assign running     = running_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a value/clocks-to-tick reference model predicts
// each tick, and a monitor matches every DUT tick against the predicted queue.
module tb_countdown_timer;

    localparam int TICK = 3;
    localparam int PERIOD = TICK + 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [3:0] hex_out_one;
    logic [3:0] hex_out_two;
    logic       tick;
    logic       expired;
    logic       running;

    countdown_timer #(.TICK_COUNT(TICK), .DIV_WIDTH(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .hex_out_one (hex_out_one),
        .hex_out_two (hex_out_two),
        .tick        (tick),
        .expired     (expired),
        .running     (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int val;
        int exp;
    } tick_exp_t;

    tick_exp_t sb_q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Reference model: race time as an integer and clocks remaining until the next tick.
    int m_mode = M_IDLE;
    int m_val  = 0;
    int m_rem  = PERIOD;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_next();
        tick_exp_t e;
        int t;
        int o;
        if (load) begin
            t = (preset_tens > 9) ? 9 : int'(preset_tens);
            o = (preset_ones > 9) ? 9 : int'(preset_ones);
            m_val  = 10 * t + o;
            m_mode = M_IDLE;
            m_rem  = PERIOD;
        end else begin
            case (m_mode)
                M_IDLE: if (enable && m_val != 0) begin
                    m_mode = M_RUN;
                    m_rem  = PERIOD;
                end
                M_RUN: begin
                    if (!enable) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_rem = PERIOD;
                            m_val--;
                            if (m_val == 0) m_mode = M_EXP;
                            e.cyc = cyc + 1;
                            e.val = m_val;
                            e.exp = (m_mode == M_EXP) ? 1 : 0;
                            sb_q.push_back(e);
                        end
                    end
                end
                M_PAUSE: if (enable) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_status();
        chk("ones", int'(hex_out_one), m_val % 10);
        chk("tens", int'(hex_out_two), m_val / 10);
        chk("running", int'(running), (m_mode == M_RUN) ? 1 : 0);
        chk("expired", int'(expired), (m_mode == M_EXP) ? 1 : 0);
    endtask

    task automatic step(input logic en, input logic ld, input logic [3:0] pt, input logic [3:0] po);
        enable      = en;
        load        = ld;
        preset_tens = pt;
        preset_ones = po;
        model_next();
        @(posedge clock);
        @(negedge clock);
        check_status();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0);
    endtask

    // Monitor: every DUT tick must match the oldest predicted tick, in value and cycle.
    initial begin
        tick_exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (tick) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_value", 10 * int'(hex_out_two) + int'(hex_out_one), e.val);
                    chk("tick_expired", int'(expired), e.exp);
                end
            end
            while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                chk("missed_tick_at", 0, e.cyc);
            end
        end
    end

    initial begin
        int n;
        int ticks;
        enable      = 1'b0;
        load        = 1'b0;
        preset_tens = 4'd0;
        preset_ones = 4'd0;
        reset_n     = 1'b0;
        #3;
        chk("reset_tick", int'(tick), 0);
        chk("reset_digits", int'({hex_out_two, hex_out_one}), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_expired", int'(expired), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Full countdown from 12 with the 10->09 borrow; expiry 48 clocks after RUN entry.
        step(1'b0, 1'b1, 4'd1, 4'd2);
        chk("load_12", 10 * int'(hex_out_two) + int'(hex_out_one), 12);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        chk("running_next_cycle", int'(running), 1);
        n = 0;
        while (!expired && n < 60) begin
            step(1'b1, 1'b0, 4'd0, 4'd0);
            n++;
        end
        chk("expire_latency", n, 48);
        chk("expire_running_low", int'(running), 0);

        // Pause for 6 cycles mid-period from 05: next tick delayed by 7.
        step(1'b0, 1'b1, 4'd0, 4'd5);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        run(PERIOD + 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd0, 4'd0);
        n = 0;
        ticks = 0;
        while (!tick && n < 20) begin
            step(1'b1, 1'b0, 4'd0, 4'd0);
            n++;
        end
        chk("resume_tick_delay", n, 4);
        run(8);

        // Clamp and the zero preset.
        step(1'b0, 1'b1, 4'hA, 4'hF);
        chk("clamp_99", 10 * int'(hex_out_two) + int'(hex_out_one), 99);
        step(1'b1, 1'b1, 4'd0, 4'd0);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'd0, 4'd0);
            ticks += int'(tick);
        end
        chk("zero_preset_no_tick", ticks, 0);

        // Load mid-run with enable held: IDLE, then RUN, first tick 4 clocks later.
        step(1'b0, 1'b1, 4'd0, 4'd7);
        run(3);
        step(1'b1, 1'b1, 4'd3, 4'd0);
        chk("reload_idle", int'(running), 0);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        chk("reload_rerun", int'(running), 1);
        run(PERIOD + 2);

        // Sticky expiry then load to clear it.
        step(1'b0, 1'b1, 4'd0, 4'd2);
        run(2 * PERIOD + 1);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 4'd0, 4'd0);
            ticks += int'(tick);
        end
        chk("expired_no_tick", ticks, 0);
        step(1'b1, 1'b1, 4'd0, 4'd2);
        chk("expired_cleared", int'(expired), 0);

        // Asynchronous reset between edges mid-run.
        step(1'b1, 1'b0, 4'd0, 4'd0);
        run(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_tick", int'(tick), 0);
        chk("async_digits", int'({hex_out_two, hex_out_one}), 0);
        chk("async_running", int'(running), 0);
        chk("async_expired", int'(expired), 0);
        sb_q.delete();
        m_mode = M_IDLE;
        m_val  = 0;
        m_rem  = PERIOD;
        @(negedge clock);
        reset_n = 1'b1;
        run(6);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic       en;
            logic       ld;
            logic [3:0] pt;
            logic [3:0] po;
            en = ($urandom % 5) != 0;
            ld = ($urandom % 40) == 0;
            pt = ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'($urandom % 2);
            po = 4'($urandom % 16);
            step(en, ld, pt, po);
        end
        run(3);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Two-digit BCD countdown timer for the race game: the down-counting counterpart of the existing 1 Hz up-counting elapsed-time display counter. It loads a preset race time, decrements once per divided tick while running, supports pause/resume, and raises a sticky `expired` flag on reaching 00. The digit outputs drive the same decimal 7-segment decoders as the up-counter (HEX0 = ones, HEX1 = tens).

## Interface
- `TICK_COUNT`, default 49_999_999: rate-divider reload value. One tick every TICK_COUNT+1 clocks, which is 1 Hz at 50 MHz.
- `DIV_WIDTH`, default 28: rate-divider register width. Must hold TICK_COUNT.
- `clock`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level: 1 = run, 0 = pause.
- `load`  in  1  synchronous load of the preset digits; highest priority after reset.
- `preset_tens`  in  4  BCD tens digit of the race time.
- `preset_ones`  in  4  BCD ones digit of the race time.
- `hex_out_one`  out  4  current ones digit, BCD.
- `hex_out_two`  out  4  current tens digit, BCD.
- `tick`  out  1  one-cycle pulse, asserted on each decrement.
- `expired`  out  1  high while in EXPIRED.
- `running`  out  1  high while in RUN.

## Operation
- States are IDLE, RUN, PAUSE and EXPIRED.
- Reset values (asynchronous): state IDLE, digits 0/0, divider = TICK_COUNT, `tick`=0, `expired`=0, `running`=0.
- `load`=1, in any state:
  - digits <= preset; any preset digit > 9 is clamped to 9.
  - divider <= TICK_COUNT.
  - state -> IDLE.
  - `enable` is ignored that cycle.
- IDLE:
  - `enable`=1 and digits != 00 -> RUN; divider <= TICK_COUNT.
  - `enable`=1 and digits == 00 -> stay in IDLE.
- RUN, `enable`=1:
  - If divider != 0, divider decrements.
  - If divider == 0, divider <= TICK_COUNT, `tick` pulses, and the digits do a BCD decrement:
    - ones != 0: ones - 1.
    - ones == 0: ones <= 9, tens - 1.
  - A decrement from 01 to 00 -> EXPIRED.
- RUN, `enable`=0 -> PAUSE. In that cycle the divider holds, no tick occurs and the digits hold, even if divider == 0.
- PAUSE:
  - Divider and digits hold.
  - `enable`=1 -> RUN, and counting resumes from the held divider value; a partial period is not restarted.
- EXPIRED:
  - Digits are 00 and `expired`=1.
  - `enable` is ignored.
  - Exits only via `load` or reset.
- Digits never leave the range 0-9. Underflow below 00 is impossible by construction.

## Timing
- All outputs are registered.
- `tick`, the digit update and the EXPIRED entry all happen on the same clock edge: the edge after divider == 0 is sampled in RUN with `enable`=1.
- `enable` sampled high in IDLE at edge N gives `running`=1 after edge N.
- The first tick occurs TICK_COUNT+1 clocks after RUN is entered. Subsequent ticks are spaced exactly TICK_COUNT+1 clocks while unpaused.
- Preset P = 10·tens + ones (≥1), uninterrupted: `expired` rises (TICK_COUNT+1)·P clocks after RUN entry, on the same edge as the final `tick`.
- Pausing for K cycles delays every later tick by exactly K+1 cycles: K in PAUSE, plus the pausing cycle itself.
- `load` takes effect at the next edge. The digit outputs show the preset one cycle after `load` is sampled.
- Asserting `reset_n` mid-run clears all state and outputs immediately, without waiting for a clock edge. Release is synchronous to the next edge.

## Test plan
All scenarios use TICK_COUNT=3, so one tick every 4 clocks.
- Load 1/2, then `enable`=1 -> `running` next cycle; digits step 12,11,10,09,...,01,00 at one tick per 4 clocks; the 10->09 borrow is correct; `expired`=1 and `running`=0 on the 12th tick, 48 clocks after RUN entry.
- Run from 05, drop `enable` for 6 cycles mid-period, then restore -> no tick and digits frozen during the pause; the next tick is delayed by exactly 7 cycles; the remaining period resumes without restart.
- Load 0xA/0xF -> digits 9/9. Load 0/0 with `enable`=1 -> stays in IDLE, no tick, `expired`=0.
- In RUN at 07, pulse `load` with 3/0 -> the next cycle is IDLE with digits 30 and divider = 3. With `enable` still high, RUN is re-entered one cycle later and the first tick comes 4 clocks after that.
- Let the timer expire, hold `enable`=1 for 20 cycles -> digits stay 00, `expired` stays 1, no `tick`. Then `load` 0/2 -> `expired` clears next cycle.
- Assert `reset_n`=0 between clock edges mid-RUN -> all outputs go to their reset values before the next edge. After release the timer remains in IDLE despite `enable`=1, because digits are 00.
